tpu_skew_feeder: RTL

- Operand feeder directly upstream of the DIM x DIM systolic MAC array.
- Captures one DIM x DIM A matrix and one DIM x DIM B matrix, one row of each per accepted beat.
- Streams both matrices into the array's A (west edge) and B (north edge) inputs with the diagonal skew the array needs, and drives the array's enable.
- After one stream, MAC(i,j) has accumulated sum over k of A[i][k]*B[k][j].

---
 rtl/tpu_skew_feeder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/tpu_skew_feeder.sv
// Operand feeder for a DIM x DIM systolic MAC array: captures A and B row by row, then
// streams them with diagonal skew. Optional ping-pong banks via TPU_SKEW_FEEDER_DBLBUF_EN.
module tpu_skew_feeder #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               load_valid,
    output logic                               load_ready,
    input  logic signed [DIM-1:0][BITS_AB-1:0] A_row,
    input  logic signed [DIM-1:0][BITS_AB-1:0] B_row,
    input  logic                               start,
    output logic signed [DIM-1:0][BITS_AB-1:0] A_out,
    output logic signed [DIM-1:0][BITS_AB-1:0] B_out,
    output logic                               en_out,
    output logic                               busy,
    output logic                               full,
    output logic                               done
);
    localparam int CW = $clog2(3*DIM);
    localparam int RW = $clog2(DIM);
    localparam logic [CW-1:0] T_LAST   = CW'(3*DIM-3);
    localparam logic [CW-1:0] ROW_LAST = CW'(DIM-1);
    localparam logic [CW-1:0] DIM_C    = CW'(DIM);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        READY  = 2'd1,
        STREAM = 2'd2
    } state_t;
    typedef logic [DIM-1:0][BITS_AB-1:0] row_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] rowcnt_reg, rowcnt_next;
    logic [CW-1:0] t_reg, t_next;
    logic          load_full_reg, load_full_next;
    logic          load_bank_reg, load_bank_next;
    logic          stream_bank_reg, stream_bank_next;
    logic          load_fire;
    logic          swap;
    logic          stream_next;
    logic          done_next;
    row_t          a_lane_next, b_lane_next;

    // Two banks are always declared; without the ping-pong option only bank 0 is ever used.
    row_t abuf [2][DIM];
    row_t bbuf [2][DIM];

`ifdef TPU_SKEW_FEEDER_DBLBUF_EN
    assign load_ready = ~load_full_reg;
`else
    assign load_ready = (state_reg == LOAD);
`endif
    assign load_fire = load_valid & load_ready;
    assign full      = load_full_reg;
    assign busy      = (state_reg == STREAM);

    always_comb begin : next_state_logic
        state_next       = state_reg;
        t_next           = t_reg;
        rowcnt_next      = rowcnt_reg;
        load_full_next   = load_full_reg;
        load_bank_next   = load_bank_reg;
        stream_bank_next = stream_bank_reg;
        swap             = 1'b0;

        if (load_fire) begin
            if (rowcnt_reg == ROW_LAST) begin
                rowcnt_next    = '0;
                load_full_next = 1'b1;
            end else begin
                rowcnt_next = rowcnt_reg + CW'(1);
            end
        end

        case (state_reg)
            LOAD: begin
                if (load_full_next) state_next = READY;
            end
            READY: begin
                if (start) swap = 1'b1;
            end
            STREAM: begin
                if (t_reg == T_LAST) begin
`ifdef TPU_SKEW_FEEDER_DBLBUF_EN
                    // Back-to-back stream: restart on the freshly loaded bank with no idle cycle.
                    if (start && load_full_reg) swap = 1'b1;
                    else state_next = load_full_next ? READY : LOAD;
`else
                    state_next = LOAD;
`endif
                end else begin
                    t_next = t_reg + CW'(1);
                end
            end
            default: state_next = LOAD;
        endcase

        if (swap) begin
            state_next       = STREAM;
            t_next           = '0;
            load_full_next   = 1'b0;
            stream_bank_next = load_bank_reg;
`ifdef TPU_SKEW_FEEDER_DBLBUF_EN
            load_bank_next   = ~load_bank_reg;
`endif
        end
    end

    always_comb begin : output_logic
        stream_next = (state_next == STREAM);
        done_next   = stream_next && (t_next == T_LAST);
    end

    // Lane gi carries element (t - gi); d goes negative (MSB set) before the lane's wavefront.
    for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
        logic [CW:0] d;
        logic        hit;
        assign d   = {1'b0, t_next} - (CW+1)'(gi);
        assign hit = stream_next && !d[CW] && (d[CW-1:0] < DIM_C);
        assign a_lane_next[gi] = hit ? abuf[stream_bank_next][gi][d[RW-1:0]] : '0;
        assign b_lane_next[gi] = hit ? bbuf[stream_bank_next][d[RW-1:0]][gi] : '0;
    end

    always_ff @(posedge clk) begin : state_register
        if (rst) begin
            state_reg       <= LOAD;
            t_reg           <= '0;
            rowcnt_reg      <= '0;
            load_full_reg   <= 1'b0;
            load_bank_reg   <= 1'b0;
            stream_bank_reg <= 1'b0;
            A_out           <= '0;
            B_out           <= '0;
            en_out          <= 1'b0;
            done            <= 1'b0;
        end else begin
            state_reg       <= state_next;
            t_reg           <= t_next;
            rowcnt_reg      <= rowcnt_next;
            load_full_reg   <= load_full_next;
            load_bank_reg   <= load_bank_next;
            stream_bank_reg <= stream_bank_next;
            A_out           <= a_lane_next;
            B_out           <= b_lane_next;
            en_out          <= stream_next;
            done            <= done_next;
        end
    end

    // Buffers keep their contents across reset; only accepted beats write them.
    always_ff @(posedge clk) begin : buffer_write
        if (load_fire && !rst) begin
            abuf[load_bank_reg][rowcnt_reg[RW-1:0]] <= A_row;
            bbuf[load_bank_reg][rowcnt_reg[RW-1:0]] <= B_row;
        end
    end

endmodule
